// File: rtl/compare_sort_ctrl.sv
// In-place bubble sorter over a small register file of signed words, sharing one
// comparator across every adjacent pair. Optional early exit: COMPARE_SORT_EARLY_EXIT_EN.

module comparator_lt #(
    parameter int N = 32
) (
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    output logic                out
);
    assign out = a < b;
endmodule

module compare_sort_ctrl #(
    parameter  int N     = 32,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_data,
    input  logic          start,
    input  logic [AW-1:0] rd_addr,
    output logic [N-1:0]  rd_data,
    output logic          busy,
    output logic          done,
    output logic [15:0]   swap_count
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CMP,
        S_SWAP,
        S_PEND,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 2);

    state_t        state, state_next;
    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] j, pass, j_hi;
    logic          dirty;
    logic          cmp_lt;
    logic          pass_finish;
    logic          sort_init, j_step, pass_step, swap_en, wr_ok;

    assign j_hi = j + AW'(1);

    comparator_lt #(.N(N)) u_cmp (
        .a   (mem[j_hi]),
        .b   (mem[j]),
        .out (cmp_lt)
    );

`ifdef COMPARE_SORT_EARLY_EXIT_EN
    // A pass with no swaps proves the array is already ordered.
    assign pass_finish = (pass == LAST) || !dirty;
`else
    assign pass_finish = (pass == LAST);
`endif

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // NOTE: every output of this block is given a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        sort_init  = 1'b0;
        j_step     = 1'b0;
        pass_step  = 1'b0;
        swap_en    = 1'b0;
        wr_ok      = 1'b0;
        case (state)
            S_IDLE: begin
                wr_ok = wr_en;
                if (start) begin
                    sort_init  = 1'b1;
                    state_next = S_CMP;
                end
            end
            S_CMP: begin
                if (cmp_lt)         state_next = S_SWAP;
                else if (j == LAST) state_next = S_PEND;
                else                j_step     = 1'b1;
            end
            S_SWAP: begin
                swap_en = 1'b1;
                if (j == LAST) begin
                    state_next = S_PEND;
                end else begin
                    j_step     = 1'b1;
                    state_next = S_CMP;
                end
            end
            S_PEND: begin
                if (pass_finish) begin
                    state_next = S_DONE;
                end else begin
                    pass_step  = 1'b1;
                    state_next = S_CMP;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: the register file is cleared by reset because a mid-sort reset must leave all entries 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            j          <= '0;
            pass       <= '0;
            dirty      <= 1'b0;
            swap_count <= '0;
        end else begin
            if (wr_ok) mem[wr_addr] <= wr_data;
            if (sort_init) begin
                j          <= '0;
                pass       <= '0;
                dirty      <= 1'b0;
                swap_count <= '0;
            end
            if (j_step) j <= j_hi;
            if (pass_step) begin
                pass  <= pass + AW'(1);
                j     <= '0;
                dirty <= 1'b0;
            end
            if (swap_en) begin
                mem[j]    <= mem[j_hi];
                mem[j_hi] <= mem[j];
                dirty     <= 1'b1;
                if (swap_count != 16'hFFFF) swap_count <= swap_count + 16'd1;
            end
        end
    end

    assign rd_data = mem[rd_addr];
    assign busy    = (state == S_CMP) || (state == S_SWAP) || (state == S_PEND);
    assign done    = (state == S_DONE);

endmodule

// File: tb/tb_compare_sort_ctrl.sv
// Directed bench for compare_sort_ctrl at DEPTH=4: reset, sort results, swap counts,
// busy latency, mid-sort reset, ignored writes/starts while busy, random loads.

module tb_compare_sort_ctrl;
    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    typedef logic [31:0] vec_t [DEPTH];

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [N-1:0]  wr_data;
    logic          start;
    logic [AW-1:0] rd_addr;
    logic [N-1:0]  rd_data;
    logic          busy;
    logic          done;
    logic [15:0]   swap_count;

    int checks   = 0;
    int failures = 0;

    compare_sort_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .swap_count (swap_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle 1 time unit so inputs/outputs are away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = v[i];
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic check_mem(input string tag, input vec_t exp);
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = AW'(i);
            #1;
            check($sformatf("%s[%0d]", tag, i), rd_data, exp[i]);
        end
    endtask

    // Pulse start for one cycle, count busy cycles until done; bounded.
    task automatic run_sort(input string tag, output int cycles);
        start = 1'b1;
        tick();
        start  = 1'b0;
        cycles = 0;
        while (!done && cycles < 500) begin
            if (busy) cycles++;
            tick();
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        tick();
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    task automatic model_sort(input vec_t in, output vec_t out, output int swaps);
        logic [31:0] t;
        out   = in;
        swaps = 0;
        for (int p = 0; p < DEPTH - 1; p++)
            for (int k = 0; k < DEPTH - 1; k++)
                if ($signed(out[k+1]) < $signed(out[k])) begin
                    t = out[k]; out[k] = out[k+1]; out[k+1] = t;
                    swaps++;
                end
    endtask

    vec_t v_in, v_exp;
    int   cyc, mswaps;

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; rd_addr = '0;
        tick();
        tick();
        rst = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_swaps", 32'(swap_count), 32'd0);
        v_exp = '{0, 0, 0, 0};
        check_mem("rst_mem", v_exp);

        // Basic sort; the last write shares its cycle with start.
        v_in = '{3, 1, 2, 0};
        for (int i = 0; i < DEPTH - 1; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = v_in[i];
            tick();
        end
        wr_addr = 2'd3; wr_data = 32'd0;
        start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        check("b_busy_after_start", 32'(busy), 32'd1);
        cyc = 1;
        tick();
        while (!done && cyc < 500) begin
            if (busy) cyc++;
            tick();
        end
        check("b_done_seen", 32'(done), 32'd1);
        check("b_cycles", 32'(cyc), 32'd17);
        check("b_swaps", 32'(swap_count), 32'd5);
        tick();
        check("b_done_one_cycle", 32'(done), 32'd0);
        check("b_swaps_stable", 32'(swap_count), 32'd5);
        v_exp = '{0, 1, 2, 3};
        check_mem("b_mem", v_exp);

        // Signed extremes.
        v_in = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h7FFF_FFFF};
        load(v_in);
        run_sort("s", cyc);
        check("s_swaps", 32'(swap_count), 32'd2);
        check("s_cycles", 32'(cyc), 32'd14);
        v_exp = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd5, 32'h7FFF_FFFF};
        check_mem("s_mem", v_exp);

        // Already sorted with a duplicate; swap_count cleared from the previous sort.
        v_in = '{1, 2, 2, 3};
        load(v_in);
        run_sort("z", cyc);
        check("z_swaps", 32'(swap_count), 32'd0);
`ifdef COMPARE_SORT_EARLY_EXIT_EN
        check("z_cycles", 32'(cyc), 32'd4);
`else
        check("z_cycles", 32'(cyc), 32'd12);
`endif
        check_mem("z_mem", v_in);

        // Reset during the 3rd busy cycle.
        v_in = '{3, 1, 2, 0};
        load(v_in);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("r_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("r_busy", 32'(busy), 32'd0);
        check("r_done", 32'(done), 32'd0);
        check("r_swaps", 32'(swap_count), 32'd0);
        v_exp = '{0, 0, 0, 0};
        check_mem("r_mem", v_exp);
        begin
            int seen = 0;
            for (int i = 0; i < 20; i++) begin
                if (done || busy) seen++;
                tick();
            end
            check("r_no_done", 32'(seen), 32'd0);
        end

        // Write and start while busy must be ignored.
        v_in = '{3, 1, 2, 0};
        load(v_in);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'd99; start = 1'b1;
        tick();
        tick();
        tick();
        wr_en = 1'b0; start = 1'b0;
        cyc = 0;
        while (!done && cyc < 500) begin
            cyc++;
            tick();
        end
        check("p_done_seen", 32'(done), 32'd1);
        check("p_swaps", 32'(swap_count), 32'd5);
        tick();
        check("p_idle", 32'(busy), 32'd0);
        v_exp = '{0, 1, 2, 3};
        check_mem("p_mem", v_exp);

        // Random loads against a behavioural bubble sort.
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < DEPTH; i++)
                v_in[i] = (it < 4) ? 32'($urandom_range(0, 7)) - 32'd4 : $urandom;
            model_sort(v_in, v_exp, mswaps);
            load(v_in);
            run_sort($sformatf("rand%0d", it), cyc);
            check($sformatf("rand%0d_swaps", it), 32'(swap_count), 32'(mswaps));
`ifndef COMPARE_SORT_EARLY_EXIT_EN
            check($sformatf("rand%0d_cycles", it), 32'(cyc), 32'(DEPTH * (DEPTH - 1) + mswaps));
`endif
            check_mem($sformatf("rand%0d_mem", it), v_exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
